// File: rtl/odd_rf_stage_if.sv
// Bundle between odd-pipe decode/write-back/hazard logic and the odd RF/FWD stage.
// The master modport drives the stage inputs; the slave modport is the stage itself.
interface odd_rf_stage_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 7
);
  logic              instr_valid;
  logic [0:10]       op_in;
  logic [2:0]        format_in;
  logic [0:17]       imm_in;
  logic [ADDR_W-1:0] rt_addr_in;
  logic              reg_write_in;
  logic [ADDR_W-1:0] ra_addr_in;
  logic [ADDR_W-1:0] rb_addr_in;
  logic [ADDR_W-1:0] rc_addr_in;
  logic              stall;
  logic              flush;
  logic [DATA_W-1:0] rt_wb_even;
  logic [DATA_W-1:0] rt_wb_odd;
  logic [ADDR_W-1:0] rt_addr_wb_even;
  logic [ADDR_W-1:0] rt_addr_wb_odd;
  logic              reg_write_wb_even;
  logic              reg_write_wb_odd;

  logic [DATA_W-1:0] ra;
  logic [DATA_W-1:0] rb;
  logic [DATA_W-1:0] rc;
  logic [0:10]       op;
  logic [2:0]        format;
  logic [0:17]       imm;
  logic [ADDR_W-1:0] rt_addr;
  logic              reg_write;
  logic [ADDR_W-1:0] ra_addr;
  logic [ADDR_W-1:0] rb_addr;
  logic [ADDR_W-1:0] rc_addr;
  logic [31:0]       stall_count;

  modport master (
    output instr_valid, op_in, format_in, imm_in, rt_addr_in, reg_write_in,
           ra_addr_in, rb_addr_in, rc_addr_in, stall, flush,
           rt_wb_even, rt_wb_odd, rt_addr_wb_even, rt_addr_wb_odd,
           reg_write_wb_even, reg_write_wb_odd,
    input  ra, rb, rc, op, format, imm, rt_addr, reg_write,
           ra_addr, rb_addr, rc_addr, stall_count
  );

  modport slave (
    input  instr_valid, op_in, format_in, imm_in, rt_addr_in, reg_write_in,
           ra_addr_in, rb_addr_in, rc_addr_in, stall, flush,
           rt_wb_even, rt_wb_odd, rt_addr_wb_even, rt_addr_wb_odd,
           reg_write_wb_even, reg_write_wb_odd,
    output ra, rb, rc, op, format, imm, rt_addr, reg_write,
           ra_addr, rb_addr, rc_addr, stall_count
  );
endinterface

// File: rtl/odd_rf_stage.sv
// Odd-pipe RF/FWD stage: 128x128 register file written by both write-back ports,
// bypassed operand read, one register stage toward the odd execution units.
module odd_rf_stage #(
  parameter int NUM_REGS = 128,
  parameter int DATA_W   = 128,
  parameter int ADDR_W   = 7
) (
  input logic           clk,
  input logic           reset,
  odd_rf_stage_if.slave bus
);

  logic [DATA_W-1:0] r_rf [NUM_REGS];

  logic [DATA_W-1:0] r_ra_p1, r_rb_p1, r_rc_p1;
  logic [0:10]       r_op_p1;
  logic [2:0]        r_format_p1;
  logic [0:17]       r_imm_p1;
  logic [ADDR_W-1:0] r_rt_addr_p1;
  logic              r_reg_write_p1;
  logic [ADDR_W-1:0] r_ra_addr_p1, r_rb_addr_p1, r_rc_addr_p1;
  logic [31:0]       r_stall_cnt;

  logic [ADDR_W-1:0] w_ra_sel, w_rb_sel, w_rc_sel;
  logic [DATA_W-1:0] w_ra_rd, w_rb_rd, w_rc_rd;

  // Odd write-back is younger than even, so it takes precedence in the bypass.
  function automatic logic [DATA_W-1:0] bypass_read(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] arr_val,
    input logic              we_e,
    input logic [ADDR_W-1:0] a_e,
    input logic [DATA_W-1:0] d_e,
    input logic              we_o,
    input logic [ADDR_W-1:0] a_o,
    input logic [DATA_W-1:0] d_o
  );
    if (we_o && (a_o == addr))      return d_o;
    else if (we_e && (a_e == addr)) return d_e;
    else                            return arr_val;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // A stalled instruction keeps re-reading its own sources so it sees producer write-backs.
  assign w_ra_sel = bus.stall ? r_ra_addr_p1 : bus.ra_addr_in;
  assign w_rb_sel = bus.stall ? r_rb_addr_p1 : bus.rb_addr_in;
  assign w_rc_sel = bus.stall ? r_rc_addr_p1 : bus.rc_addr_in;

  assign w_ra_rd = bypass_read(w_ra_sel, r_rf[w_ra_sel], bus.reg_write_wb_even,
                               bus.rt_addr_wb_even, bus.rt_wb_even, bus.reg_write_wb_odd,
                               bus.rt_addr_wb_odd, bus.rt_wb_odd);
  assign w_rb_rd = bypass_read(w_rb_sel, r_rf[w_rb_sel], bus.reg_write_wb_even,
                               bus.rt_addr_wb_even, bus.rt_wb_even, bus.reg_write_wb_odd,
                               bus.rt_addr_wb_odd, bus.rt_wb_odd);
  assign w_rc_rd = bypass_read(w_rc_sel, r_rf[w_rc_sel], bus.reg_write_wb_even,
                               bus.rt_addr_wb_even, bus.rt_wb_even, bus.reg_write_wb_odd,
                               bus.rt_addr_wb_odd, bus.rt_wb_odd);

  // Register file array: odd port written last so it wins an address collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_rf[i] <= '0;
    end else begin
      if (bus.reg_write_wb_even) r_rf[bus.rt_addr_wb_even] <= bus.rt_wb_even;
      if (bus.reg_write_wb_odd)  r_rf[bus.rt_addr_wb_odd]  <= bus.rt_wb_odd;
    end
  end

  // Stage p0 -> p1: operands and decoded fields toward the odd execution units.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || bus.flush) begin
      r_ra_p1        <= '0;
      r_rb_p1        <= '0;
      r_rc_p1        <= '0;
      r_op_p1        <= '0;
      r_format_p1    <= '0;
      r_imm_p1       <= '0;
      r_rt_addr_p1   <= '0;
      r_reg_write_p1 <= 1'b0;
      r_ra_addr_p1   <= '0;
      r_rb_addr_p1   <= '0;
      r_rc_addr_p1   <= '0;
    end else if (bus.stall) begin
      r_ra_p1 <= w_ra_rd;
      r_rb_p1 <= w_rb_rd;
      r_rc_p1 <= w_rc_rd;
    end else if (bus.instr_valid) begin
      r_ra_p1        <= w_ra_rd;
      r_rb_p1        <= w_rb_rd;
      r_rc_p1        <= w_rc_rd;
      r_op_p1        <= bus.op_in;
      r_format_p1    <= bus.format_in;
      r_imm_p1       <= bus.imm_in;
      r_rt_addr_p1   <= bus.rt_addr_in;
      r_reg_write_p1 <= bus.reg_write_in;
      r_ra_addr_p1   <= bus.ra_addr_in;
      r_rb_addr_p1   <= bus.rb_addr_in;
      r_rc_addr_p1   <= bus.rc_addr_in;
    end else begin
      r_ra_p1        <= '0;
      r_rb_p1        <= '0;
      r_rc_p1        <= '0;
      r_op_p1        <= '0;
      r_format_p1    <= '0;
      r_imm_p1       <= '0;
      r_rt_addr_p1   <= '0;
      r_reg_write_p1 <= 1'b0;
      r_ra_addr_p1   <= '0;
      r_rb_addr_p1   <= '0;
      r_rc_addr_p1   <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        r_stall_cnt <= '0;
    else if (bus.stall && !bus.flush) r_stall_cnt <= sat_inc(r_stall_cnt);
  end

  assign bus.ra          = r_ra_p1;
  assign bus.rb          = r_rb_p1;
  assign bus.rc          = r_rc_p1;
  assign bus.op          = r_op_p1;
  assign bus.format      = r_format_p1;
  assign bus.imm         = r_imm_p1;
  assign bus.rt_addr     = r_rt_addr_p1;
  assign bus.reg_write   = r_reg_write_p1;
  assign bus.ra_addr     = r_ra_addr_p1;
  assign bus.rb_addr     = r_rb_addr_p1;
  assign bus.rc_addr     = r_rc_addr_p1;
  assign bus.stall_count = r_stall_cnt;

endmodule

// File: tb/tb_odd_rf_stage.sv
// Directed bench for odd_rf_stage: write/read, bypass, collision, stall refresh, flush, reset.
module tb_odd_rf_stage;
  localparam int NUM_REGS = 128;
  localparam int DATA_W   = 128;
  localparam int ADDR_W   = 7;

  localparam logic [127:0] D0123 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] D55   = {16{8'h55}};
  localparam logic [127:0] D11   = {16{8'h11}};
  localparam logic [127:0] D22   = {16{8'h22}};
  localparam logic [127:0] D33   = {16{8'h33}};
  localparam logic [127:0] DFF   = {16{8'hFF}};
  localparam logic [127:0] DAA   = {16{8'hAA}};
  localparam logic [0:10]  ROTQBY = 11'b00111011100;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  odd_rf_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  odd_rf_stage #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.instr_valid       = 1'b0;
    bus.op_in             = '0;
    bus.format_in         = '0;
    bus.imm_in            = '0;
    bus.rt_addr_in        = '0;
    bus.reg_write_in      = 1'b0;
    bus.ra_addr_in        = '0;
    bus.rb_addr_in        = '0;
    bus.rc_addr_in        = '0;
    bus.stall             = 1'b0;
    bus.flush             = 1'b0;
    bus.rt_wb_even        = '0;
    bus.rt_wb_odd         = '0;
    bus.rt_addr_wb_even   = '0;
    bus.rt_addr_wb_odd    = '0;
    bus.reg_write_wb_even = 1'b0;
    bus.reg_write_wb_odd  = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    idle_inputs();
    #12;
    chk("rst_op", bus.op, 0);
    chk("rst_reg_write", bus.reg_write, 0);
    chk("rst_ra", bus.ra, 0);
    chk("rst_stall_count", bus.stall_count, 0);
    reset = 1'b0;
    step();

    // Write r3 through even port, then read it.
    bus.reg_write_wb_even = 1'b1; bus.rt_addr_wb_even = 7'd3; bus.rt_wb_even = D0123;
    step();
    chk("nop_reg_write", bus.reg_write, 0);
    idle_inputs();
    bus.instr_valid = 1'b1; bus.ra_addr_in = 7'd3; bus.op_in = 11'h2A5;
    bus.format_in = 3'd5; bus.imm_in = 18'h2ABCD; bus.rt_addr_in = 7'd20; bus.reg_write_in = 1'b1;
    step();
    chk("wr_rd_ra", bus.ra, D0123);
    chk("wr_rd_op", bus.op, 11'h2A5);
    chk("wr_rd_format", bus.format, 3'd5);
    chk("wr_rd_imm", bus.imm, 18'h2ABCD);
    chk("wr_rd_rt_addr", bus.rt_addr, 7'd20);
    chk("wr_rd_reg_write", bus.reg_write, 1);
    chk("wr_rd_ra_addr", bus.ra_addr, 7'd3);

    // Same-cycle odd bypass on rb, then array read-back.
    idle_inputs();
    bus.instr_valid = 1'b1; bus.rb_addr_in = 7'd9;
    bus.reg_write_wb_odd = 1'b1; bus.rt_addr_wb_odd = 7'd9; bus.rt_wb_odd = D55;
    step();
    chk("byp_odd_rb", bus.rb, D55);
    idle_inputs();
    bus.instr_valid = 1'b1; bus.rb_addr_in = 7'd9;
    step();
    chk("arr_r9", bus.rb, D55);

    // Even/odd collision on r12, plus an even-only bypass on ra.
    idle_inputs();
    bus.instr_valid = 1'b1; bus.rc_addr_in = 7'd12;
    bus.reg_write_wb_even = 1'b1; bus.rt_addr_wb_even = 7'd12; bus.rt_wb_even = D11;
    bus.reg_write_wb_odd  = 1'b1; bus.rt_addr_wb_odd  = 7'd12; bus.rt_wb_odd  = D22;
    step();
    chk("collide_byp_rc", bus.rc, D22);
    idle_inputs();
    bus.instr_valid = 1'b1; bus.rc_addr_in = 7'd12; bus.ra_addr_in = 7'd13;
    bus.reg_write_wb_even = 1'b1; bus.rt_addr_wb_even = 7'd13; bus.rt_wb_even = D33;
    step();
    chk("collide_arr_r12", bus.rc, D22);
    chk("byp_even_ra", bus.ra, D33);

    // Stall refresh: rotqby reading r7, odd write-back of r7 in stall cycle 2.
    idle_inputs();
    bus.instr_valid = 1'b1; bus.op_in = ROTQBY; bus.ra_addr_in = 7'd7; bus.reg_write_in = 1'b1;
    step();
    chk("rot_op", bus.op, ROTQBY);
    chk("rot_ra_pre", bus.ra, 0);
    bus.stall = 1'b1; bus.op_in = 11'h7FF; bus.ra_addr_in = 7'd3;
    step();
    chk("stall1_op", bus.op, ROTQBY);
    chk("stall1_ra_addr", bus.ra_addr, 7'd7);
    chk("stall1_ra", bus.ra, 0);
    chk("stall1_count", bus.stall_count, 1);
    bus.reg_write_wb_odd = 1'b1; bus.rt_addr_wb_odd = 7'd7; bus.rt_wb_odd = DFF;
    step();
    chk("stall2_ra", bus.ra, DFF);
    chk("stall2_op", bus.op, ROTQBY);
    bus.reg_write_wb_odd = 1'b0;
    step();
    chk("stall3_ra", bus.ra, DFF);
    chk("stall3_op", bus.op, ROTQBY);
    chk("stall3_count", bus.stall_count, 3);

    // Flush together with stall kills the held instruction, count unchanged.
    bus.flush = 1'b1;
    step();
    chk("flush_reg_write", bus.reg_write, 0);
    chk("flush_op", bus.op, 0);
    chk("flush_format", bus.format, 0);
    chk("flush_ra", bus.ra, 0);
    chk("flush_count", bus.stall_count, 3);
    idle_inputs();
    bus.instr_valid = 1'b1; bus.op_in = 11'h123; bus.reg_write_in = 1'b1; bus.ra_addr_in = 7'd3;
    step();
    chk("post_flush_op", bus.op, 11'h123);
    chk("post_flush_ra", bus.ra, D0123);
    chk("post_flush_count", bus.stall_count, 3);

    // Reset mid-run clears outputs immediately and wipes the array.
    idle_inputs();
    bus.reg_write_wb_even = 1'b1; bus.rt_addr_wb_even = 7'd5; bus.rt_wb_even = DAA;
    step();
    idle_inputs();
    bus.instr_valid = 1'b1; bus.ra_addr_in = 7'd5; bus.op_in = 11'h055; bus.reg_write_in = 1'b1;
    step();
    chk("pre_rst_ra", bus.ra, DAA);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_ra", bus.ra, 0);
    chk("mid_rst_op", bus.op, 0);
    chk("mid_rst_reg_write", bus.reg_write, 0);
    chk("mid_rst_count", bus.stall_count, 0);
    #2 reset = 1'b0;
    step();
    chk("after_rst_ra", bus.ra, 0);
    chk("after_rst_op", bus.op, 11'h055);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/odd_rf_stage.md
Name: odd_rf_stage

Overview:
- RF/FWD stage of the odd pipe. Holds the 128 x 128-bit SPU register file.
- Each cycle it reads the odd instruction's ra/rb/rc and registers operands plus decoded fields toward the odd execution units (permute, load/store, branch).
- Both pipes' write-back ports write the array, so even and odd copies stay coherent. Same-cycle write-back is bypassed into the read.
- Holds under RAW stall, inserts a nop on branch flush, and counts stall cycles.

Parameters:
NUM_REGS, 128, register file depth
DATA_W, 128, register width in bits
ADDR_W, 7, register address width

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-high
instr_valid  in  1  decoded odd instruction present this cycle
op_in  in  11  decoded opcode [0:10]
format_in  in  3  instruction format
imm_in  in  18  immediate [0:17]
rt_addr_in  in  7  destination address
reg_write_in  in  1  instruction writes RF
ra_addr_in, rb_addr_in, rc_addr_in  in  7 each  source addresses
stall  in  1  RAW stall from execution stage; hold outputs
flush  in  1  branch taken; kill instruction entering stage
rt_wb_even, rt_wb_odd  in  128 each  write-back data
rt_addr_wb_even, rt_addr_wb_odd  in  7 each  write-back address
reg_write_wb_even, reg_write_wb_odd  in  1 each  write-back enable
ra, rb, rc  out  128 each  registered operand values
op, format, imm, rt_addr, reg_write  out  11/3/18/7/1  registered instruction fields
ra_addr, rb_addr, rc_addr  out  7 each  registered source addresses (for RAW compare)
stall_count  out  32  saturating count of stall cycles

Behaviour:
- Reset (async, any time):
  - All NUM_REGS entries become 0.
  - All outputs become 0, so op=0/format=0 is a nop and reg_write=0.
  - stall_count becomes 0.
  - An in-flight instruction is dropped.
- Writes, at posedge:
  - entry[rt_addr_wb_even] <= rt_wb_even if reg_write_wb_even.
  - entry[rt_addr_wb_odd] <= rt_wb_odd if reg_write_wb_odd.
  - If both target the same address, odd data wins (odd is younger in program order).
  - Writes happen regardless of stall or flush.
  - Register 0 is an ordinary register.
- Read with bypass, for each source s in {ra, rb, rc}:
  - next value = rt_wb_odd if reg_write_wb_odd and address match;
  - else rt_wb_even if reg_write_wb_even and address match;
  - else entry[address].
  - This value is registered at the posedge, so latency is one cycle from address to operand output.
- Address used for reads: *_addr_in when advancing; the held output addresses (ra_addr/rb_addr/rc_addr) while stalled.
- Priority each posedge: reset > flush > stall > advance.
  - flush=1: op, format, imm, rt_addr, reg_write and the source addresses go to 0. Operands go to 0. Flush while stalled also kills the held instruction.
  - stall=1 (no flush): instruction fields and addresses hold. Operands are re-read from the held addresses with bypass, so the held instruction picks up a producer's write-back during the stall.
  - Advance: if instr_valid=1, capture all *_in fields and read operands. If instr_valid=0, load a nop (all fields 0, reg_write=0).
- stall_count increments on every posedge with stall=1 and flush=0. It saturates at 0xFFFFFFFF and never wraps.
- No combinational path from inputs to outputs. All outputs come from flops.

Test Plan:
- Reset mid-run: preload r5=0xAA..AA, pulse reset between edges -> all outputs 0 immediately; a later read of r5 returns 0.
- Write then read: write r3=0x0123..EF via even port at edge N, issue ra_addr_in=3 at edge N+1 -> ra=0x0123..EF after N+1.
- Same-cycle bypass: issue rb_addr_in=9 while reg_write_wb_odd=1, rt_addr_wb_odd=9, rt_wb_odd=0x55..55 -> rb=0x55..55 one cycle later; array r9=0x55..55.
- Dual-write collision: even writes r12=0x11..11 and odd writes r12=0x22..22 in the same cycle, with rc_addr_in=12 -> rc=0x22..22; later read of r12 also returns 0x22..22.
- Stall refresh: instruction rotqby (op=0b00111011100), ra_addr=7, held under stall for 3 cycles; odd write-back of r7=0xFF..FF in stall cycle 2 -> op unchanged throughout, ra=0xFF..FF after that edge, stall_count=3.
- Flush overrides stall: stall=1 and flush=1 together -> next cycle reg_write=0, op=0, format=0, stall_count unchanged; following instr_valid=1 instruction advances normally.
